// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared register-file widths, write-back state and request types
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam int                    REG_DATA_W = 32;
    localparam int                    NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } wb_state_t;

    // Field is reg_idx because "reg" is a reserved word.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] reg_idx;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin arbiter, search starts at ptr
// Revision   : 1.0
// ============================================================================
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic w_found;

    // Offset k is the search priority: lowest offset from ptr that requests wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter : clears the register file after reset, then shares its
//                      write port between NUM_REQ round-robin requesters
// Revision           : 1.0
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = regfile_pkg::REG_ADDR_W,
    parameter int DATA_W   = regfile_pkg::REG_DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]           write_reg,
    output logic [DATA_W-1:0]           write_data,
    output logic                        write_enable,
    output logic                        init_done,
    output logic [1:0]                  grant_id
);

    localparam logic [0:0]      ST_INIT = 1'b0;
    localparam logic [0:0]      ST_RUN  = 1'b1;
    localparam logic [ADDR_W:0] C_LAST  = (ADDR_W+1)'(NUM_REGS - 1);

    logic [0:0]         state_q, state_d;
    logic [ADDR_W:0]    clr_cnt_q, clr_cnt_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic               write_enable_q, write_enable_d;
    logic [ADDR_W-1:0]  write_reg_q, write_reg_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;
    logic               init_done_q, init_done_d;
    logic [1:0]         grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] w_gnt;
    logic [1:0]         w_gnt_idx;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_sel_reg;
    logic [DATA_W-1:0]  w_sel_data;
    logic [ADDR_W-1:0]  w_req_reg  [NUM_REQ];
    logic [DATA_W-1:0]  w_req_data [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_reg[gi]  = req_reg[gi*ADDR_W +: ADDR_W];
            assign w_req_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (2)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready = (state_q == ST_RUN) ? w_gnt : '0;
    assign w_xfer    = (state_q == ST_RUN) && (|(req_valid & w_gnt));

    always_comb begin
        w_sel_reg  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_reg  = w_req_reg[i];
                w_sel_data = w_req_data[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        write_enable_d = 1'b0;
        write_reg_d    = write_reg_q;
        write_data_d   = write_data_q;
        init_done_d    = init_done_q;
        grant_id_d     = grant_id_q;
        if (state_q == ST_INIT) begin
            write_enable_d = 1'b1;
            write_reg_d    = clr_cnt_q[ADDR_W-1:0];
            write_data_d   = '0;
            clr_cnt_d      = clr_cnt_q + (ADDR_W+1)'(1);
            if (clr_cnt_q == C_LAST) begin
                state_d = ST_RUN;
            end
        end else begin
            init_done_d = 1'b1;
            if (w_xfer) begin
                // x0 writes are still accepted so the requester can retire them.
                write_enable_d = (w_sel_reg != '0);
                write_reg_d    = w_sel_reg;
                write_data_d   = w_sel_data;
                grant_id_d     = w_gnt_idx;
                rr_ptr_d       = (w_gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : w_gnt_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_INIT;
            clr_cnt_q      <= '0;
            rr_ptr_q       <= '0;
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            init_done_q    <= 1'b0;
            grant_id_q     <= '0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            write_enable_q <= write_enable_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            init_done_q    <= init_done_d;
            grant_id_q     <= grant_id_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign init_done    = init_done_q;
    assign grant_id     = grant_id_q;

endmodule
`default_nettype wire
